traceback_prefetch_buffer: RTL and testbench

//  Ping-pong buffer directly downstream of the traceback prefetch column finder. Captures each

---
 rtl/traceback_prefetch_buffer_pkg.sv | 35 +++
 rtl/traceback_prefetch_buffer_bank.sv | 28 ++
 rtl/traceback_prefetch_buffer.sv | 128 ++++++++++++
 tb/tb_traceback_prefetch_buffer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/traceback_prefetch_buffer_pkg.sv
// Shared widths, state encodings and request codes for the traceback prefetch buffer.
package traceback_prefetch_buffer_pkg;

   localparam int unsigned DIRECTION_WIDTH = 5;
   localparam int unsigned PREFETCH_LENGTH = 8;
   localparam int unsigned PF_PTR_W        = $clog2(PREFETCH_LENGTH);
   localparam int unsigned WINDOW_W        = PREFETCH_LENGTH * DIRECTION_WIDTH;

   // Request codes, also decoded by the column finder.
   localparam logic [1:0] REQ_NONE = 2'b00;
   localparam logic [1:0] REQ_CUR  = 2'b01;
   localparam logic [1:0] REQ_PF   = 2'b10;

   typedef enum logic [2:0] {
      S_EMPTY   = 3'd0,
      S_ACTIVE  = 3'd1,
      S_FULL    = 3'd2,
      S_WAIT_PF = 3'd3,
      S_DISCARD = 3'd4
   } state_t;

   // Upstream request implied by a buffer state.
   function automatic logic [1:0] req_of(input state_t s);
      logic [1:0] r;
      r = REQ_NONE;
      case (s)
         S_EMPTY:   r = REQ_CUR;
         S_ACTIVE:  r = REQ_PF;
         S_WAIT_PF: r = REQ_PF;
         default:   r = REQ_NONE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/traceback_prefetch_buffer_bank.sv
// One window of traceback directions: whole-window write, sync clear, indexed read.
module traceback_prefetch_bank
   import traceback_prefetch_buffer_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       we,
   input  logic [0:WINDOW_W-1]        wdata,
   input  logic [PF_PTR_W-1:0]        rd_idx,
   output logic [DIRECTION_WIDTH-1:0] rd_data
);

   logic [DIRECTION_WIDTH-1:0] mem [PREFETCH_LENGTH];

   // Capture the full window in one cycle; entry 0 is the leftmost slice.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int i = 0; i < int'(PREFETCH_LENGTH); i++) mem[i] <= '0;
      end else if (we) begin
         for (int i = 0; i < int'(PREFETCH_LENGTH); i++)
            mem[i] <= wdata[i*DIRECTION_WIDTH +: DIRECTION_WIDTH];
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/traceback_prefetch_buffer.sv
// Ping-pong direction buffer between the prefetch column finder and the traceback walker.
module traceback_prefetch_buffer
   import traceback_prefetch_buffer_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [0:WINDOW_W-1]        prefetch_column,
   input  logic                       column_valid,
   input  logic                       flush,
   input  logic                       pop,
   output logic [1:0]                 prefetch_request,
   output logic [DIRECTION_WIDTH-1:0] dir_out,
   output logic                       dir_valid
);

   state_t                     state, state_nxt;
   logic [PF_PTR_W-1:0]        rd_ptr, rd_ptr_nxt;
   logic                       active_sel, active_sel_nxt;
   logic                       wr_en, wr_bank;
   logic                       do_pop, accept, last;
   logic [DIRECTION_WIDTH-1:0] rd_data0, rd_data1;

   // State, read pointer, bank select and the registered upstream request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_EMPTY;
         rd_ptr           <= '0;
         active_sel       <= 1'b0;
         prefetch_request <= REQ_NONE;
      end else begin
         state            <= state_nxt;
         rd_ptr           <= rd_ptr_nxt;
         active_sel       <= active_sel_nxt;
         prefetch_request <= req_of(state_nxt);
      end
   end

   // Next-state, bank write steering and walker-facing outputs.
   always_comb begin
      state_nxt      = state;
      rd_ptr_nxt     = rd_ptr;
      active_sel_nxt = active_sel;
      wr_en          = 1'b0;
      wr_bank        = active_sel;
      dir_valid      = (state == S_ACTIVE) || (state == S_FULL);
      dir_out        = '0;
      if (dir_valid) dir_out = active_sel ? rd_data1 : rd_data0;

      do_pop = pop && dir_valid;
      accept = column_valid && (prefetch_request != REQ_NONE);
      last   = (rd_ptr == PF_PTR_W'(PREFETCH_LENGTH - 1));

      if (flush) begin
         rd_ptr_nxt     = '0;
         active_sel_nxt = 1'b0;
         // A column still in flight must be dropped, even if flushed again while waiting for it.
         state_nxt = ((state == S_DISCARD) || (prefetch_request != REQ_NONE)) ? S_DISCARD : S_EMPTY;
      end else begin
         case (state)
            S_EMPTY, S_WAIT_PF: begin
               if (accept) begin
                  wr_en      = 1'b1;
                  wr_bank    = active_sel;
                  rd_ptr_nxt = '0;
                  state_nxt  = S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               if (do_pop && last) begin
                  rd_ptr_nxt = '0;
                  if (accept) begin
                     // Arriving window becomes active immediately: no bubble.
                     wr_en          = 1'b1;
                     wr_bank        = ~active_sel;
                     active_sel_nxt = ~active_sel;
                     state_nxt      = S_ACTIVE;
                  end else begin
                     state_nxt = S_WAIT_PF;
                  end
               end else begin
                  if (do_pop) rd_ptr_nxt = PF_PTR_W'(rd_ptr + 1'b1);
                  if (accept) begin
                     wr_en     = 1'b1;
                     wr_bank   = ~active_sel;
                     state_nxt = S_FULL;
                  end
               end
            end
            S_FULL: begin
               if (do_pop) begin
                  if (last) begin
                     rd_ptr_nxt     = '0;
                     active_sel_nxt = ~active_sel;
                     state_nxt      = S_ACTIVE;
                  end else begin
                     rd_ptr_nxt = PF_PTR_W'(rd_ptr + 1'b1);
                  end
               end
            end
            S_DISCARD: begin
               if (column_valid) state_nxt = S_EMPTY;
            end
            default: state_nxt = S_EMPTY;
         endcase
      end
   end

   traceback_prefetch_bank u_bank0 (
      .clk     (clk),
      .rst     (rst),
      .clear   (flush),
      .we      (wr_en && !wr_bank),
      .wdata   (prefetch_column),
      .rd_idx  (rd_ptr),
      .rd_data (rd_data0)
   );

   traceback_prefetch_bank u_bank1 (
      .clk     (clk),
      .rst     (rst),
      .clear   (flush),
      .we      (wr_en && wr_bank),
      .wdata   (prefetch_column),
      .rd_idx  (rd_ptr),
      .rd_data (rd_data1)
   );

endmodule

// File: tb/tb_traceback_prefetch_buffer.sv
// Scoreboard bench: queue-of-windows reference model, monitor compares every cycle.
module tb_traceback_prefetch_buffer;
   import traceback_prefetch_buffer_pkg::*;

   localparam int L = int'(PREFETCH_LENGTH);
   localparam int W = int'(DIRECTION_WIDTH);

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic [0:WINDOW_W-1]        prefetch_column = '0;
   logic                       column_valid = 1'b0;
   logic                       flush = 1'b0;
   logic                       pop = 1'b0;
   logic [1:0]                 prefetch_request;
   logic [DIRECTION_WIDTH-1:0] dir_out;
   logic                       dir_valid;

   traceback_prefetch_buffer dut (
      .clk              (clk),
      .rst              (rst),
      .prefetch_column  (prefetch_column),
      .column_valid     (column_valid),
      .flush            (flush),
      .pop              (pop),
      .prefetch_request (prefetch_request),
      .dir_out          (dir_out),
      .dir_valid        (dir_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int req;
      bit vld;
      int dir;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: directions left in the active window, a waiting window,
   // the request currently outstanding and whether an in-flight column must be dropped.
   int act_q[$];
   int shd_q[$];
   int req_m  = 0;
   bit disc_m = 1'b0;
   int win_v[L];

   function automatic void model_step(input bit r, input bit f, input bit p, input bit c);
      int col[$];
      bit acc, was_pf;
      exp_t e;
      for (int i = 0; i < L; i++) col.push_back(win_v[i]);
      if (r) begin
         act_q.delete(); shd_q.delete();
         disc_m = 1'b0;
         req_m  = 0;
      end else if (f) begin
         disc_m = disc_m || (req_m != 0);
         act_q.delete(); shd_q.delete();
         req_m = disc_m ? 0 : 1;
      end else begin
         acc    = c && (req_m != 0);
         was_pf = (req_m == 2);
         if (disc_m) begin
            if (c) disc_m = 1'b0;
         end else begin
            if (p && act_q.size() > 0) void'(act_q.pop_front());
            if (acc) begin
               if (act_q.size() == 0) act_q = col;
               else shd_q = col;
            end
            if (act_q.size() == 0 && shd_q.size() > 0) begin
               act_q = shd_q;
               shd_q.delete();
            end
         end
         if (disc_m) req_m = 0;
         else if (act_q.size() == 0) req_m = (was_pf && !acc) ? 2 : 1;
         else if (shd_q.size() == 0) req_m = 2;
         else req_m = 0;
      end
      e.req = req_m;
      e.vld = (act_q.size() > 0);
      e.dir = e.vld ? act_q[0] : 0;
      exp_q.push_back(e);
   endfunction

   // One clock of stimulus; model advances on the same edge as the DUT.
   task automatic cyc(input bit r, input bit f, input bit p, input bit c);
      rst          = r;
      flush        = f;
      pop          = p;
      column_valid = c;
      for (int i = 0; i < L; i++) prefetch_column[i*W +: W] = DIRECTION_WIDTH'(win_v[i]);
      @(posedge clk);
      model_step(r, f, p, c);
      @(negedge clk);
   endtask

   task automatic set_win(input int base);
      for (int i = 0; i < L; i++) win_v[i] = (base + i) % (1 << W);
   endtask

   // Monitor: pop expectations and compare just after each active edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (int'(prefetch_request) != e.req) begin
               bad++;
               $display("FAIL req t=%0t got=%0d exp=%0d", $time, prefetch_request, e.req);
            end
            total++;
            if (dir_valid != e.vld) begin
               bad++;
               $display("FAIL dir_valid t=%0t got=%0b exp=%0b", $time, dir_valid, e.vld);
            end
            total++;
            if (int'(dir_out) != e.dir) begin
               bad++;
               $display("FAIL dir_out t=%0t got=%0d exp=%0d", $time, dir_out, e.dir);
            end
         end
      end
   end

   initial begin
      set_win(0);
      @(negedge clk);
      // Reset hold and release
      repeat (3) cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      // Fill then drain into the prefetch wait
      set_win(1); cyc(0, 0, 0, 1);
      repeat (L - 1) cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      // Ping-pong: two windows, continuous pops
      set_win(1);     cyc(0, 0, 0, 1);
      set_win(L + 1); cyc(0, 0, 0, 1);
      repeat (2 * L) cyc(0, 0, 1, 0);
      // Last pop coinciding with the prefetched window
      set_win(1); cyc(0, 0, 0, 1);
      repeat (L - 1) cyc(0, 0, 1, 0);
      set_win(2 * L + 1); cyc(0, 0, 1, 1);
      cyc(0, 0, 1, 0);
      // Flush with a prefetch outstanding, stale column dropped
      cyc(0, 1, 0, 0);
      for (int i = 0; i < L; i++) win_v[i] = 7;
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      set_win(1); cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 0);
      // Column offered with no request outstanding is ignored
      set_win(L + 1); cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 0);
      // Reset while both banks are valid
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < L; i++) win_v[i] = int'($urandom_range(0, (1 << W) - 1));
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40);
      end
      cyc(0, 0, 0, 0);
      @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
